amx_nibble_loader: RTL
======================

AMX_NIBBLE_LOADER -- requirements
Module: amx_nibble_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive cycles (1..15) the synchronised strobe must differ from its debounced value before the debounced value flips.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 nib_in  input  4  raw nibble from pins; asynchronous to clk.
REQ-005 strobe_in  input  1  raw load strobe from pin; asynchronous to clk; a debounced rising edge loads one nibble.
REQ-006 mode_in  input  1  raw mode pin; 0 = nibble mode, 1 = byte-assembly mode.
REQ-007 data_out  output  8  word presented to the downstream amx core.
REQ-008 data_valid  output  1  data_out holds a word not yet accepted.
REQ-009 data_ready  input  1  downstream accepts data_out in any cycle where data_valid and data_ready are both high.
REQ-010 overrun  output  1  sticky flag: a strobe edge was dropped.
REQ-011 busy  output  1  high in HIGH_HELD or HOLD.

Function
REQ-012 nib_in, strobe_in and mode_in SHALL each pass through a 2-flop synchroniser before any other use.
REQ-013 Debounce: a counter SHALL increment each cycle the synchronised strobe differs from deb_strobe. It SHALL clear whenever they match. deb_strobe SHALL toggle, and the counter clear, on the cycle the count reaches DEBOUNCE_CYCLES.
REQ-014 A load event SHALL be a 0->1 transition of deb_strobe. The nibble SHALL be sampled from the synchronised nib_in on the edge that follows the deb_strobe rise.
REQ-015 The state machine SHALL have three states: IDLE, HIGH_HELD and HOLD.
REQ-016 IDLE, nibble mode: a load event SHALL set data_out = {4'h0, nib} and move to HOLD.
REQ-017 IDLE, byte mode: a load event SHALL store nib as the high nibble and move to HIGH_HELD.
REQ-018 HIGH_HELD: a load event SHALL set data_out = {high, nib} and move to HOLD.
REQ-019 HOLD: data_valid SHALL be 1. On data_valid and data_ready, the state SHALL move to IDLE and data_valid SHALL be 0 the next cycle.
REQ-020 data_out SHALL stay stable while data_valid is 1.
REQ-021 data_out SHALL keep its last value after acceptance, until the next load.
REQ-022 Latency: let edge 0 be the first clk edge sampling strobe_in high, with the strobe held clean. data_valid SHALL rise after edge DEBOUNCE_CYCLES+2, i.e. edge 6 at the default.
REQ-023 A load event in HOLD SHALL be discarded, SHALL set overrun to 1, and SHALL leave data_out unchanged.
REQ-024 overrun SHALL stay 1 until reset.
REQ-025 A change of the synchronised mode while in HIGH_HELD SHALL discard the held nibble and return to IDLE; no word is emitted.
REQ-026 A mode change in HOLD SHALL not affect the pending word.
REQ-027 If a load event and acceptance occur in the same cycle in HOLD, the acceptance SHALL complete and the load SHALL count as an overrun.
REQ-028 data_ready SHALL be ignored while data_valid is 0.
REQ-029 Strobe glitches shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no load event.

Reset
REQ-030 While rst_n is sampled low: state = IDLE, data_out = 8'h00, data_valid = 0, overrun = 0, busy = 0.
REQ-031 While rst_n is sampled low: synchroniser flops, deb_strobe, the debounce counter and the held nibble SHALL all be 0.
REQ-032 Reset asserted mid-operation, in any state, SHALL abandon any partial or pending word with no output for it.
REQ-033 After reset releases, a strobe_in already high SHALL produce one load event once debounced, since deb_strobe restarts at 0.

Verification
REQ-034 Nibble mode, nib_in=4'hA, strobe 0->1 held 10 cycles, data_ready=1 -> data_valid high for exactly 1 cycle after edge 6 with data_out=8'h0A, then busy=0.
REQ-035 Byte mode, nibbles 4'h3 then 4'hC on two clean strobes, data_ready=0 -> data_out=8'h3C with data_valid held high; raise data_ready -> data_valid=0 next cycle.
REQ-036 Strobe pulses of 2 and 3 clk cycles, DEBOUNCE_CYCLES=4 -> no data_valid, state stays IDLE.
REQ-037 Nibble mode, word 8'h05 pending with data_ready=0, then a second strobe with nib 4'h7 -> data_out stays 8'h05 and overrun=1; after acceptance overrun remains 1.
REQ-038 Byte mode, one nibble 4'h9 loaded (busy=1), then mode_in driven 0 -> busy=0 within 3 cycles; next strobe with 4'h2 gives data_out=8'h02.
REQ-039 rst_n low for 1 cycle while in HOLD with 8'hFF pending -> next cycle data_valid=0, data_out=8'h00, overrun=0.

Source files
------------

// File: rtl/amx_nibble_loader_if.sv
// Pin-side and downstream handshake signals of the amx nibble loader.
// The loader sits on the slave side; whoever drives the pins and consumes words is the master.
interface amx_nibble_loader_if;
   logic [3:0] nib_in;
   logic       strobe_in;
   logic       mode_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       overrun;
   logic       busy;

   modport slave (
      input  nib_in,
      input  strobe_in,
      input  mode_in,
      input  data_ready,
      output data_out,
      output data_valid,
      output overrun,
      output busy
   );

   modport master (
      output nib_in,
      output strobe_in,
      output mode_in,
      output data_ready,
      input  data_out,
      input  data_valid,
      input  overrun,
      input  busy
   );
endinterface

// File: rtl/amx_nibble_loader.sv
// Loads nibbles from asynchronous pins on a debounced strobe and presents them,
// alone or paired into a byte, to the amx core through a valid/ready handshake.
module amx_nibble_loader #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   amx_nibble_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HIGH_HELD = 2'd1,
      HOLD      = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

   // Synchroniser stages
   logic [3:0] nib_s1;
   logic [3:0] nib_s2;
   logic       strobe_s1;
   logic       strobe_s2;
   logic       mode_s1;
   logic       mode_s2;

   // Debounce and edge detect
   logic [3:0] deb_cnt;
   logic       deb_strobe;
   logic       deb_strobe_q;
   logic       load_event;

   // Control and datapath
   state_t     state;
   state_t     state_next;
   logic       load_low;
   logic       load_high;
   logic       load_pair;
   logic       load_drop;
   logic       discard_high;
   logic [3:0] high_nib;
   logic [7:0] data_q;
   logic       overrun_q;

   // NOTE: every clocked process uses non-blocking (<=) so all flops update
   // together from pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nib_s1    <= 4'h0;
         nib_s2    <= 4'h0;
         strobe_s1 <= 1'b0;
         strobe_s2 <= 1'b0;
         mode_s1   <= 1'b0;
         mode_s2   <= 1'b0;
      end else begin
         nib_s1    <= bus.nib_in;
         nib_s2    <= nib_s1;
         strobe_s1 <= bus.strobe_in;
         strobe_s2 <= strobe_s1;
         mode_s1   <= bus.mode_in;
         mode_s2   <= mode_s1;
      end
   end

   // The counter runs only while the synchronised strobe disagrees with the
   // debounced one; the flip happens on the cycle the count would reach the limit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_cnt      <= 4'h0;
         deb_strobe   <= 1'b0;
         deb_strobe_q <= 1'b0;
      end else begin
         deb_strobe_q <= deb_strobe;
         if (strobe_s2 == deb_strobe) begin
            deb_cnt <= 4'h0;
         end else if (deb_cnt == CNT_LAST) begin
            deb_cnt    <= 4'h0;
            deb_strobe <= ~deb_strobe;
         end else begin
            deb_cnt <= deb_cnt + 4'h1;
         end
      end
   end

   assign load_event = deb_strobe & ~deb_strobe_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a mode flip while half a byte is held wins over a load.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_next unassigned, which would otherwise infer a latch.
      state_next = state;
      case (state)
         IDLE: begin
            if (load_event) begin
               state_next = mode_s2 ? HIGH_HELD : HOLD;
            end
         end
         HIGH_HELD: begin
            if (!mode_s2) begin
               state_next = IDLE;
            end else if (load_event) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (bus.data_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output and datapath-control decode
   always_comb begin
      load_low       = 1'b0;
      load_high      = 1'b0;
      load_pair      = 1'b0;
      load_drop      = 1'b0;
      discard_high   = 1'b0;
      bus.data_valid = 1'b0;
      bus.busy       = 1'b0;
      case (state)
         IDLE: begin
            load_low  = load_event & ~mode_s2;
            load_high = load_event & mode_s2;
         end
         HIGH_HELD: begin
            bus.busy     = 1'b1;
            discard_high = ~mode_s2;
            load_pair    = load_event & mode_s2;
         end
         HOLD: begin
            bus.busy       = 1'b1;
            bus.data_valid = 1'b1;
            load_drop      = load_event;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

   // data_q only changes on an accepted load, so it is stable while valid
   // and keeps its last word after acceptance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         high_nib  <= 4'h0;
         data_q    <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         if (load_high) begin
            high_nib <= nib_s2;
         end else if (discard_high || load_pair) begin
            high_nib <= 4'h0;
         end

         if (load_low) begin
            data_q <= {4'h0, nib_s2};
         end else if (load_pair) begin
            data_q <= {high_nib, nib_s2};
         end

         if (load_drop) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign bus.data_out = data_q;
   assign bus.overrun  = overrun_q;

endmodule
